memory_boot_ram: RTL

- Parametrised single-port synchronous RAM with an integrated boot loader. Generalises the fixed 256x8 program memory.
- After reset, an internal sequencer optionally zero-fills the array, then accepts a streamed image over a valid/ready port. Only after that does it hand the array to the CPU port.
- Sits between the off-chip/testbench image source and the CPU fetch/data path. Replaces file-preloaded memory with a loadable one.

---
 rtl/memory_boot_ram_if.sv | 30 +++
 rtl/memory_boot_ram.sv | 130 +++++++++++++
 2 files changed

// File: rtl/memory_boot_ram_if.sv
// CPU and boot-loader port bundle for memory_boot_ram.
// master: image source / CPU side; slave: the RAM.
interface memory_boot_ram_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 8
);
   // CPU port
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] d_i;
   logic [DATA_W-1:0] d_o;
   logic              ready;
   // Loader port
   logic              load_start;
   logic              load_valid;
   logic [DATA_W-1:0] load_data;
   logic              load_last;
   logic              load_ready;
   logic [ADDR_W:0]   load_count;

   modport master (
      output we, addr, d_i, load_start, load_valid, load_data, load_last,
      input  d_o, ready, load_ready, load_count
   );

   modport slave (
      input  we, addr, d_i, load_start, load_valid, load_data, load_last,
      output d_o, ready, load_ready, load_count
   );
endinterface

// File: rtl/memory_boot_ram.sv
// Single-port synchronous RAM with a boot sequencer: optional zero-fill,
// then a streamed image load, then the array is handed to the CPU port.
module memory_boot_ram #(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned ADDR_W   = 8,
   parameter bit          CLEAR_EN = 1'b1
) (
   input logic              clk,
   input logic              rst_n,
   memory_boot_ram_if.slave bus
);
   localparam int unsigned       DEPTH    = 2 ** ADDR_W;
   localparam int unsigned       CNT_W    = ADDR_W + 1;
   localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEPTH);

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_LOAD  = 2'd1,
      ST_RUN   = 2'd2
   } state_t;

   localparam state_t ST_INIT = CLEAR_EN ? ST_CLEAR : ST_LOAD;

   logic [DATA_W-1:0] mem [DEPTH];

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [CNT_W-1:0]  load_count_q, load_count_d;
   logic [DATA_W-1:0] d_o_q;
   logic              ready_q;
   logic              load_ready_q;

   logic              mem_we_c;
   logic [ADDR_W-1:0] mem_addr_c;
   logic [DATA_W-1:0] mem_wdata_c;
   logic              load_fire_c;

   // A loader word is taken only while the registered load_ready is high
   assign load_fire_c = bus.load_valid && load_ready_q;

   // Next-state, pointer, counter and array write-port selection
   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      load_count_d = load_count_q;
      mem_we_c     = 1'b0;
      mem_addr_c   = ptr_q;
      mem_wdata_c  = '0;

      case (state_q)
         ST_CLEAR: begin
            mem_we_c = 1'b1;
            ptr_d    = ptr_q + ADDR_W'(1);
            if (ptr_q == PTR_LAST) begin
               state_d      = ST_LOAD;
               load_count_d = '0;
            end
         end

         ST_LOAD: begin
            if (load_fire_c) begin
               mem_we_c    = 1'b1;
               mem_wdata_c = bus.load_data;
               ptr_d       = ptr_q + ADDR_W'(1);
               if (load_count_q != CNT_MAX) begin
                  load_count_d = load_count_q + CNT_W'(1);
               end
               // Explicit last word or a full image both end the session
               if (bus.load_last || (ptr_q == PTR_LAST)) begin
                  state_d = ST_RUN;
                  ptr_d   = '0;
               end
            end
         end

         ST_RUN: begin
            mem_we_c    = bus.we;
            mem_addr_c  = bus.addr;
            mem_wdata_c = bus.d_i;
            if (bus.load_start) begin
               state_d      = ST_LOAD;
               ptr_d        = '0;
               load_count_d = '0;
            end
         end

         default: begin
            state_d = ST_INIT;
            ptr_d   = '0;
         end
      endcase
   end

   // Sequencer state and registered outputs; d_o is forced to 0 outside RUN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_INIT;
         ptr_q        <= '0;
         load_count_q <= '0;
         d_o_q        <= '0;
         ready_q      <= 1'b0;
         load_ready_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         load_count_q <= load_count_d;
         ready_q      <= (state_d == ST_RUN);
         load_ready_q <= (state_d == ST_LOAD);
         if ((state_q == ST_RUN) && (state_d == ST_RUN)) begin
            d_o_q <= mem[bus.addr];
         end else begin
            d_o_q <= '0;
         end
      end
   end

   // Array write port; contents deliberately survive reset
   always_ff @(posedge clk) begin
      if (mem_we_c) begin
         mem[mem_addr_c] <= mem_wdata_c;
      end
   end

   assign bus.d_o        = d_o_q;
   assign bus.ready      = ready_q;
   assign bus.load_ready = load_ready_q;
   assign bus.load_count = load_count_q;

endmodule
